pipe_stage_skid: RTL

Parametrised, flow-controlled pipeline stage register with a two-entry skid buffer, synchronous flush and valid/ready handshakes on both sides. It generalises the fixed 16-bit IF/ID latch into a reusable stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM). It carries a PC field and an instruction/payload field and supports independent upstream and downstream stalls. No data is lost, and neither side sees a combinational ready path.

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Flow-controlled pipeline stage register with a two-entry skid buffer.
//   Entries leave in arrival order; in_ready, out_valid and count are flop
//   outputs, so neither handshake side sees a combinational ready path.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   Reset      synchronous active-high reset (priority over everything)
//   Flush      synchronous squash of all held entries
//   in_valid   upstream presents in_pc/in_ir
//   in_ready   stage can accept this cycle (registered)
//   in_pc      upstream PC
//   in_ir      upstream instruction/payload
//   out_valid  out_pc/out_ir hold a valid entry (registered)
//   out_ready  downstream accepts this cycle
//   out_pc     head entry PC
//   out_ir     head entry IR
//   count      number of held entries (0..2)
module pipe_stage_skid #(
  parameter int unsigned          PC_W   = 16,
  parameter int unsigned          IR_W   = 16,
  parameter logic [IR_W-1:0]      NOP_IR = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [IR_W-1:0] in_ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [IR_W-1:0] out_ir,
  output logic [1:0]      count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            in_ready_q, out_valid_q;
  logic [1:0]      count_q;
  logic            in_ready_nxt, out_valid_nxt;
  logic [1:0]      count_nxt;

  logic [PC_W-1:0] main_pc, skid_pc;
  logic [IR_W-1:0] main_ir, skid_ir;

  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // State register; the handshake flags are registered copies decoded
  // from the next state so they never depend combinationally on inputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      count_q     <= count_nxt;
    end
  end

  // Next-state and datapath load selection.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      // Any same-cycle in_fire is dropped; an out_fire is simply consumed.
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_nxt = S_EMPTY;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = S_ONE;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Output decode of the next state, registered above.
  always_comb begin
    in_ready_nxt  = (state_nxt != S_FULL);
    out_valid_nxt = (state_nxt != S_EMPTY);
    case (state_nxt)
      S_ONE:   count_nxt = 2'd1;
      S_FULL:  count_nxt = 2'd2;
      default: count_nxt = 2'd0;
    endcase
  end

  // Main (head) register: cleared to the bubble on reset/flush, otherwise
  // reloaded only on an advance so out_* stays stable while held.
  always_ff @(posedge CLK) begin
    if (Reset || Flush) begin
      main_pc <= '0;
      main_ir <= NOP_IR;
    end else if (load_main_in) begin
      main_pc <= in_pc;
      main_ir <= in_ir;
    end else if (load_main_skid) begin
      main_pc <= skid_pc;
      main_ir <= skid_ir;
    end
  end

  // Skid register contents are only meaningful in FULL.
  always_ff @(posedge CLK) begin
    if (load_skid) begin
      skid_pc <= in_pc;
      skid_ir <= in_ir;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign out_pc    = main_pc;
  assign out_ir    = main_ir;

endmodule
